// File: rtl/key_debounce_pkg.sv
// Shared types for the keypad debounce block.
// Optional auto-repeat is enabled with KEY_DEBOUNCE_REPEAT_EN.
package key_debounce_pkg;
  localparam int KEY_WIDTH = 4;

  typedef logic [KEY_WIDTH-1:0] key_event_t;

  localparam key_event_t KEY_NONE = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    PRESSED,
    RELEASE
  } state_t;
endpackage

// File: rtl/key_debounce_fifo.sv
// Small event FIFO between the debouncer and the lock FSM.
// A push into a full FIFO succeeds only when a pop frees a slot.
module key_event_fifo
  import key_debounce_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output key_event_t head,
  output logic       valid,
  output logic       full,
  output logic       drop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  key_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = valid ? mem[rd_ptr] : KEY_NONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/key_debounce.sv
// Keypad debounce FSM feeding a valid/ready event FIFO.
// Define KEY_DEBOUNCE_REPEAT_EN for auto-repeat while a key is held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 12,
  parameter int CNT_WIDTH     = 5,
  parameter int FIFO_DEPTH    = 4
`ifdef KEY_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 24
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 key_valid,
  output logic [KEY_WIDTH-1:0] key_code,
  input  logic                 key_ready,
  output logic                 key_held,
  output logic                 overflow
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_t               state, state_n;
  key_event_t           cand, cand_n;
  logic [CNT_WIDTH-1:0] count, count_n;
  logic                 push_press;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cand     <= KEY_NONE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cand     <= cand_n;
      count    <= count_n;
      overflow <= overflow | (fifo_drop & fifo_full);
    end
  end

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    count_n    = count;
    push_press = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_in != KEY_NONE) begin
          cand_n  = key_in;
          count_n = ONE;
          state_n = CONFIRM;
        end
      end
      CONFIRM: begin
        if (key_in == cand) begin
          if (count == LAST) begin
            push_press = 1'b1;
            count_n    = '0;
            state_n    = PRESSED;
          end else begin
            count_n = count + 1'b1;
          end
        end else if (key_in == KEY_NONE) begin
          count_n = '0;
          state_n = IDLE;
        end else begin
          cand_n  = key_in;
          count_n = ONE;
        end
      end
      PRESSED: begin
        if (key_in != cand) begin
          count_n = ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (key_in == KEY_NONE) begin
          if (count == LAST) begin
            cand_n  = KEY_NONE;
            count_n = '0;
            state_n = IDLE;
          end else begin
            count_n = count + 1'b1;
          end
        end else if (key_in == cand) begin
          count_n = '0;
          state_n = PRESSED;
        end else begin
          count_n = ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] RLAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] rpt_q;
  logic                 stay;
  logic                 rpt_hit;

  // Counts only uninterrupted PRESSED cycles; any exit restarts it.
  assign stay    = (state == PRESSED) && (state_n == PRESSED);
  assign rpt_hit = stay && (rpt_q == RLAST);
  assign push    = push_press | rpt_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        rpt_q <= '0;
    else if (rpt_hit) rpt_q <= '0;
    else if (stay)    rpt_q <= rpt_q + 1'b1;
    else              rpt_q <= '0;
  end
`else
  assign push = push_press;
`endif

  assign key_held = (state == PRESSED) || (state == RELEASE);

  key_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(cand),
    .pop      (key_ready),
    .head     (key_code),
    .valid    (key_valid),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Sits between the keypad row/column scanner and the code-lock FSM.
- Consumes the scanner's raw 4-bit key code. Code 0 means no key; codes 1..12 are keys.
- Filters bounce and scan glitches, then emits exactly one event per physical press.
- Events are buffered in a small FIFO and handed downstream over a valid/ready handshake, so keys pressed while the consumer stalls are not lost.

Parameters:
- STABLE_CYCLES, 12, consecutive identical samples needed to accept a press or a release. Minimum 2; default is 3 full 4-row scan frames.
- CNT_WIDTH, 5, stability-counter width. Must satisfy 2**CNT_WIDTH > STABLE_CYCLES, and 2**CNT_WIDTH > REPEAT_CYCLES when repeat is compiled in.
- FIFO_DEPTH, 4, event FIFO entries. Power of two, at least 2.
- REPEAT_CYCLES, 24, auto-repeat period. Used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_in  in  4  raw scan code from scanner; 0 = none
- key_valid  out  1  FIFO head holds an event
- key_code  out  4  FIFO head code; 0 whenever key_valid=0
- key_ready  in  1  consumer accepts head when key_valid&&key_ready
- key_held  out  1  a debounced key is currently down
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, candidate=0, count=0.
  - FIFO empty, so key_valid=0 and key_code=0.
  - key_held=0, overflow=0.
- Reset mid-operation discards candidate and all buffered events immediately.
- key_in is sampled on every rising clock edge.
- FSM states: IDLE, CONFIRM, PRESSED, RELEASE.
- IDLE:
  - key_in!=0: candidate<=key_in, count<=1, go to CONFIRM.
  - Otherwise stay in IDLE.
- CONFIRM:
  - key_in==candidate: count++.
  - When count would reach STABLE_CYCLES: push candidate, go to PRESSED, key_held<=1.
  - key_in==0: go to IDLE, count<=0.
  - Different nonzero key_in: reload candidate, count<=1, stay in CONFIRM.
- PRESSED:
  - key_in!=candidate (including a different nonzero code): count<=1, go to RELEASE.
  - Otherwise hold.
- RELEASE:
  - key_in==0: count++. At STABLE_CYCLES: go to IDLE, key_held<=0, candidate<=0.
  - key_in==candidate: return to PRESSED, no new event.
  - Other nonzero code: count<=1, stay in RELEASE.
  - Rollover is not supported: a second key registers only after a full release.
- Latency: code applied before edge e0 and held is pushed at edge e0+STABLE_CYCLES-1. key_valid is high from that edge.
- FIFO:
  - key_valid = not empty; key_code = head (registered storage); pop on key_valid&&key_ready.
  - Push when full with no pop: new event dropped, overflow<=1 until reset, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle while empty: push only, because key_valid was 0.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- key_ready with key_valid=0 is ignored.
- key_code is stable while key_valid&&!key_ready.

Optional Feature:
- Macro: KEY_DEBOUNCE_REPEAT_EN.
- Defined:
  - A separate repeat counter runs in PRESSED.
  - Every REPEAT_CYCLES consecutive cycles in PRESSED pushes another copy of candidate, subject to the normal overflow rule.
  - The counter clears on leaving PRESSED.
  - A RELEASE->PRESSED bounce restarts it at 0.
- Undefined: exactly one event per press; repeat counter and parameter use are absent.

Decomposition:
- Package key_debounce_pkg:
  - KEY_NONE=4'd0, KEY_WIDTH=4.
  - State typedef enum {IDLE, CONFIRM, PRESSED, RELEASE}.
  - A key_event_t typedef, 4-bit code.
- One sub-module, key_event_fifo:
  - Parameterised by FIFO_DEPTH.
  - Ports: clock, reset, push, push_data, pop, head, valid, full, drop.
- The debounce FSM stays in key_debounce.

Test Plan:
1. key_in=5 held 20 cycles, then 0 held 20, key_ready=1 → one event with key_code=5 for exactly one cycle. Push at edge 12; key_held 1→0 at the release edge (start of 0 + 11).
2. key_in toggles 5/0 every 3 cycles for 40 cycles → no event, key_held=0, state back in IDLE.
3. key_ready=0; press and release 5, 4, 6, 1, 11 in turn → first four codes buffered in order; 11 dropped; overflow=1. Then key_ready=1 drains 5, 4, 6, 1.
4. FIFO full; raise key_ready on the exact cycle the next press confirms → push and pop both succeed, overflow stays 0, occupancy stays 4.
5. Press 8 until key_held=1, assert reset mid-hold → key_valid=0, key_held=0, key_code=0 asynchronously. After deassert, the still-held 8 produces a fresh event 12 edges later.
6. With KEY_DEBOUNCE_REPEAT_EN, hold 2 for 12+3×24 cycles, key_ready=1 → events at edges 12, 36, 60, 84, all code 2. Without the macro, one event only.
